load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the CPU data-memory interface: takes one load/store request from the
//  execute stage (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) and sequences word-wide accesses to the
//  word-addressed data RAM, which has a combinational read and a clocked write.
//  Byte and halfword stores are done as read-modify-write because the RAM has no byte enables.
//  Loads are lane-extracted and sign/zero-extended. Stalls the pipeline via Busy.
// PARAMETERS
//  ADDRESS_WIDTH  20  word-address width of the data RAM (RAM depth = 2**ADDRESS_WIDTH words)
//  DATA_WIDTH     32  data width; fixed at 32 for RV32I lane logic
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous active-high reset
//  MemReq     in   1              request strobe; sampled only in IDLE
//  MemWrite   in   1              1 = store, 0 = load
//  Funct3     in   3              RV32I funct3 access size/sign
//  ALUresult  in   DATA_WIDTH     byte address
//  WriteData  in   DATA_WIDTH     store data, right-aligned
//  ReadData   out  DATA_WIDTH     extended load result; held until the next load completes
//  Busy       out  1              state != IDLE
//  Done       out  1              1-cycle completion pulse
//  Fault      out  1              valid with Done: misaligned access or illegal Funct3
//  MemAddr    out  ADDRESS_WIDTH  RAM word address = latched addr[ADDRESS_WIDTH+1:2]
//  MemWEN     out  1              RAM write enable
//  MemWData   out  DATA_WIDTH     RAM write word
//  MemRData   in   DATA_WIDTH     RAM read word, combinational from MemAddr
// BEHAVIOUR
//  Reset: state=IDLE; ReadData=0; Done=0; Fault=0; MemWEN=0; MemWData=0; internal latches=0.
//  IDLE: on MemReq, latch addr/op/Funct3/WriteData, then check legality:
//   - Illegal: load Funct3 in {3,6,7}, store Funct3 > 2, half with addr[0]=1, word with addr[1:0]!=0.
//   - Illegal -> FAULT. Legal load -> READ. SW -> WRITE. SB/SH -> READ.
//  READ: MemAddr driven; MemRData captured at the clock edge.
//   - Load -> DONE; ReadData updated at this edge.
//   - SB/SH -> WRITE; captured word merged with the store bytes.
//  WRITE: MemWEN=1 for exactly this cycle, MemWData = merged (SB/SH) or full (SW) word -> DONE.
//  DONE: Done=1, Fault=0 -> IDLE. FAULT: Done=1, Fault=1, no RAM write, ReadData unchanged -> IDLE.
//  Latency from request edge to Done cycle: LW/LB/LH = 2 cycles; SW = 2; SB/SH = 3; fault = 1.
//  MemReq is ignored while Busy. A new request is accepted in the cycle after Done (IDLE).
//  Lane select: byte lane = addr[1:0]; half lane = addr[1].
//   - LB/LH sign-extend from bit 7/15 of the lane. LBU/LHU zero-extend.
//   - SB/SH replace only the addressed lane; the other bytes keep their read value.
//  MemAddr: taken from the latched address in every non-IDLE state. In IDLE it is driven from ALUresult.
//  Address bits above ADDRESS_WIDTH+1 are ignored, so the word address wraps modulo RAM depth.
//  rst mid-operation: MemWEN = (state==WRITE) && !rst, so no RAM write happens in a reset cycle.
//   The next state is IDLE, and no Done is produced for the aborted request.
//  rst and MemReq in the same cycle: reset wins; the request is dropped.
// STRUCTURE
//  Package lsu_pkg holds:
//   - lsu_state_t enum {IDLE, READ, WRITE, DONE, FAULT}
//   - funct3 localparams F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5
//  Sub-module lsu_align (combinational) holds load extract/extend, store merge and the misalign check.
//  The top level holds the FSM and the registers only.
// TESTING
//  LW addr 0x8, RAM[2]=0xDEADBEEF -> Done 2 cycles after the request edge, ReadData=0xDEADBEEF,
//   Fault=0, MemWEN never 1.
//  LB 0x9 and LBU 0x9, RAM[2]=0x0000_80FF -> LB ReadData=0xFFFFFF80; LBU ReadData=0x00000080.
//  SB addr 0x6 data 0x000000AB, RAM[1]=0x11223344 -> READ, then one WRITE cycle with
//   MemAddr=1 and MemWData=0x11AB3344; Done on the 3rd cycle after the request edge.
//  LH addr 0x3 and SW addr 0x2 -> Done+Fault on the next cycle, no MemWEN, ReadData unchanged;
//   same response for load with Funct3=3.
//  SH asserted, rst pulsed in its WRITE cycle -> MemWEN stays 0, RAM unchanged, IDLE next cycle,
//   no Done; a following SW completes normally.
//  Back-to-back: MemReq held high through a LW -> the second request is accepted only in the
//   IDLE cycle after Done; Busy pattern 1,1,0,1...

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding and funct3 codes for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        FAULT
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Funct3 codes that name a real access for the given direction.
    function automatic logic f3_supported(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension, store merge and legality check
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_data,
    output logic        illegal
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Pick the addressed byte and halfword out of the read word.
    always_comb begin
        byte_val = rdata[7:0];
        case (byte_off)
            2'd0:    byte_val = rdata[7:0];
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            default: byte_val = rdata[31:24];
        endcase
        half_val = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Sign- or zero-extend the selected lane into the load result.
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_BU:   load_data = {24'd0, byte_val};
            F3_HU:   load_data = {16'd0, half_val};
            default: load_data = rdata;
        endcase
    end

    // Overlay the store bytes on the read word; untouched lanes keep their old value.
    always_comb begin
        merged_data = rdata;
        case (funct3)
            F3_B: begin
                case (byte_off)
                    2'd0:    merged_data[7:0]   = store_data[7:0];
                    2'd1:    merged_data[15:8]  = store_data[7:0];
                    2'd2:    merged_data[23:16] = store_data[7:0];
                    default: merged_data[31:24] = store_data[7:0];
                endcase
            end
            F3_H: begin
                if (byte_off[1]) begin
                    merged_data[31:16] = store_data[15:0];
                end else begin
                    merged_data[15:0] = store_data[15:0];
                end
            end
            default: merged_data = store_data;
        endcase
    end

    // Reject unknown funct3 codes and accesses not aligned to their own size.
    always_comb begin
        illegal = !f3_supported(is_store, funct3);
        if ((funct3[1:0] == 2'b01) && byte_off[0]) begin
            illegal = 1'b1;
        end
        if ((funct3 == F3_W) && (byte_off != 2'b00)) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator FSM with read-modify-write for sub-word stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MemReq,
    input  logic                     MemWrite,
    input  logic [2:0]               Funct3,
    input  logic [DATA_WIDTH-1:0]    ALUresult,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    output logic [DATA_WIDTH-1:0]    ReadData,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Fault,
    output logic [ADDRESS_WIDTH-1:0] MemAddr,
    output logic                     MemWEN,
    output logic [DATA_WIDTH-1:0]    MemWData,
    input  logic [DATA_WIDTH-1:0]    MemRData
);

    lsu_state_t               state;
    logic [ADDRESS_WIDTH+1:0] addr_q;
    logic                     is_store_q;
    logic [2:0]               f3_q;
    logic [DATA_WIDTH-1:0]    wdata_q;

    logic                     idle;
    logic [1:0]               al_off;
    logic [2:0]               al_f3;
    logic                     al_store;
    logic [DATA_WIDTH-1:0]    load_data;
    logic [DATA_WIDTH-1:0]    merged_data;
    logic                     illegal;

    // Byte-address bits above the RAM range never reach the RAM; the word address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ALUresult[DATA_WIDTH-1:ADDRESS_WIDTH+2];

    assign idle = (state == IDLE);

    // In IDLE the legality check looks at the incoming request; afterwards at the latched one.
    always_comb begin
        al_off   = idle ? ALUresult[1:0] : addr_q[1:0];
        al_f3    = idle ? Funct3 : f3_q;
        al_store = idle ? MemWrite : is_store_q;
    end

    lsu_align u_align (
        .byte_off    (al_off),
        .funct3      (al_f3),
        .is_store    (al_store),
        .rdata       (MemRData),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_data (merged_data),
        .illegal     (illegal)
    );

    // RAM address follows the request in IDLE so a read can start from the latched copy next cycle.
    always_comb begin
        MemAddr = idle ? ALUresult[ADDRESS_WIDTH+1:2] : addr_q[ADDRESS_WIDTH+1:2];
        MemWEN  = (state == WRITE) && !rst;
        Busy    = !idle;
    end

    // Request sequencing, operand latches and registered Done/Fault/ReadData/MemWData.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            is_store_q <= 1'b0;
            f3_q       <= '0;
            wdata_q    <= '0;
            ReadData   <= '0;
            Done       <= 1'b0;
            Fault      <= 1'b0;
            MemWData   <= '0;
        end else begin
            Done  <= 1'b0;
            Fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemReq) begin
                        addr_q     <= ALUresult[ADDRESS_WIDTH+1:0];
                        is_store_q <= MemWrite;
                        f3_q       <= Funct3;
                        wdata_q    <= WriteData;
                        if (illegal) begin
                            state <= FAULT;
                            Done  <= 1'b1;
                            Fault <= 1'b1;
                        end else if (!MemWrite) begin
                            state <= READ;
                        end else if (Funct3 == F3_W) begin
                            state    <= WRITE;
                            MemWData <= WriteData;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (is_store_q) begin
                        MemWData <= merged_data;
                        state    <= WRITE;
                    end else begin
                        ReadData <= load_data;
                        Done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                WRITE: begin
                    Done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against a byte-level model
module tb_load_store_unit;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          MemReq;
    logic          MemWrite;
    logic [2:0]    Funct3;
    logic [DW-1:0] ALUresult;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;
    logic          Busy;
    logic          Done;
    logic          Fault;
    logic [AW-1:0] MemAddr;
    logic          MemWEN;
    logic [DW-1:0] MemWData;
    logic [DW-1:0] MemRData;

    int checks = 0;
    int errors = 0;

    logic [31:0]   ram [0:(1<<AW)-1];
    logic          poke_en;
    logic [AW-1:0] poke_addr;
    logic [31:0]   poke_data;

    logic [31:0]   mdl [int unsigned];
    logic [31:0]   exp_rd;

    int            obs_lat;
    logic [31:0]   obs_rd;
    logic [31:0]   obs_wen_a;
    logic [31:0]   obs_wen_d;

    load_store_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUresult (ALUresult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Busy      (Busy),
        .Done      (Done),
        .Fault     (Fault),
        .MemAddr   (MemAddr),
        .MemWEN    (MemWEN),
        .MemWData  (MemWData),
        .MemRData  (MemRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign MemRData = ram[MemAddr];

    always @(posedge clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (MemWEN) ram[MemAddr] <= MemWData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int unsigned widx, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = AW'(widx);
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
        mdl[widx] = d;
    endtask

    task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic flt,
                         output logic [31:0] rd, output int wen_n, output logic [31:0] wen_a,
                         output logic [31:0] wen_d, output logic busy1,
                         output logic [31:0] idle_addr);
        @(negedge clk);
        MemReq    = 1'b1;
        MemWrite  = wr;
        Funct3    = f3;
        ALUresult = addr;
        WriteData = wd;
        #1 idle_addr = 32'(MemAddr);
        @(posedge clk);
        #1;
        MemReq    = 1'b0;
        MemWrite  = 1'($urandom_range(0, 1));
        Funct3    = 3'($urandom_range(0, 7));
        ALUresult = $urandom();
        WriteData = $urandom();
        lat = 0; flt = 1'b0; rd = '0; wen_n = 0; wen_a = '0; wen_d = '0; busy1 = 1'b0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = Busy;
            if (MemWEN) begin
                wen_n++;
                wen_a = 32'(MemAddr);
                wen_d = MemWData;
            end
            if (Done) begin
                lat = k;
                flt = Fault;
                rd  = ReadData;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int unsigned widx;
        int unsigned off;
        int unsigned size;
        logic        legal_f3;
        logic        exp_fault;
        int          exp_lat;
        logic [31:0] w, sh, nw;
        logic [7:0]  b8;
        logic [15:0] h16;
        int          lat, wen_n;
        logic        flt, busy1;
        logic [31:0] rd, wen_a, wen_d, idle_addr;

        widx = (addr >> 2) & ((1 << AW) - 1);
        off  = addr & 32'd3;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal_f3  = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_fault = !legal_f3 || ((addr % size) != 0);
        exp_lat   = exp_fault ? 1 : (!wr ? 2 : (f3 == 3'd2 ? 2 : 3));
        w   = mdl.exists(widx) ? mdl[widx] : 32'h0;
        sh  = w >> (8 * off);
        b8  = sh[7:0];
        h16 = sh[15:0];
        nw  = w;
        if (!exp_fault && !wr) begin
            case (f3)
                3'd0:    exp_rd = {{24{b8[7]}}, b8};
                3'd1:    exp_rd = {{16{h16[15]}}, h16};
                3'd4:    exp_rd = {24'd0, b8};
                3'd5:    exp_rd = {16'd0, h16};
                default: exp_rd = w;
            endcase
        end
        if (!exp_fault && wr) begin
            if (f3 == 3'd0) nw[8*off +: 8] = wd[7:0];
            else if (f3 == 3'd1) nw[8*off +: 16] = wd[15:0];
            else nw = wd;
        end

        do_op(wr, f3, addr, wd, lat, flt, rd, wen_n, wen_a, wen_d, busy1, idle_addr);
        obs_lat = lat; obs_rd = rd; obs_wen_a = wen_a; obs_wen_d = wen_d;

        check({tag, "_idle_addr"}, idle_addr, widx);
        check({tag, "_busy"}, 32'(busy1), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_fault"}, 32'(flt), 32'(exp_fault));
        check({tag, "_readdata"}, rd, exp_rd);
        check({tag, "_wen_count"}, 32'(wen_n), (wr && !exp_fault) ? 32'd1 : 32'd0);
        if (wr && !exp_fault) begin
            check({tag, "_wen_addr"}, wen_a, widx);
            check({tag, "_wen_data"}, wen_d, nw);
            check({tag, "_ram_after"}, ram[widx], nw);
            mdl[widx] = nw;
        end
    endtask

    initial begin : stim
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        busy_seq [1:5];
        logic        done_seq [1:5];

        rst = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
        ALUresult = '0; WriteData = '0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        exp_rd = '0;
        repeat (2) @(posedge clk);
        #1 MemReq = 1'b1; ALUresult = 32'h8; Funct3 = 3'd2;
        @(posedge clk);
        #1 rst = 1'b0; MemReq = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_fault", 32'(Fault), 32'd0);
        check("reset_wen", 32'(MemWEN), 32'd0);
        check("reset_wdata", MemWData, 32'd0);
        check("reset_readdata", ReadData, 32'd0);

        poke(2, 32'hDEADBEEF);
        run_op("lw8", 1'b0, 3'd2, 32'h8, 32'h0);
        check("lw8_value", obs_rd, 32'hDEADBEEF);

        poke(2, 32'h0000_80FF);
        run_op("lb9", 1'b0, 3'd0, 32'h9, 32'h0);
        check("lb9_value", obs_rd, 32'hFFFFFF80);
        run_op("lbu9", 1'b0, 3'd4, 32'h9, 32'h0);
        check("lbu9_value", obs_rd, 32'h00000080);

        poke(1, 32'h11223344);
        run_op("sb6", 1'b1, 3'd0, 32'h6, 32'h000000AB);
        check("sb6_addr", obs_wen_a, 32'd1);
        check("sb6_data", obs_wen_d, 32'h11AB3344);
        check("sb6_lat", 32'(obs_lat), 32'd3);

        run_op("lh3_fault", 1'b0, 3'd1, 32'h3, 32'h0);
        check("lh3_rd_kept", obs_rd, 32'h00000080);
        run_op("sw2_fault", 1'b1, 3'd2, 32'h2, 32'h12345678);
        run_op("ld_f3_3", 1'b0, 3'd3, 32'h8, 32'h0);
        run_op("st_f3_4", 1'b1, 3'd4, 32'h4, 32'h0);
        run_op("lw_wrap", 1'b0, 3'd2, 32'hFFC0_0008, 32'h0);
        check("lw_wrap_value", obs_rd, 32'h0000_80FF);

        // SH aborted by reset in its WRITE cycle
        @(negedge clk);
        MemReq = 1'b1; MemWrite = 1'b1; Funct3 = 3'd1; ALUresult = 32'h4; WriteData = 32'h5555;
        @(posedge clk);
        #1 MemReq = 1'b0;
        @(negedge clk);
        check("rst_sh_read_busy", 32'(Busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_sh_wen", 32'(MemWEN), 32'd0);
        check("rst_sh_done", 32'(Done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_rd = 32'h0;
        @(negedge clk);
        check("rst_sh_idle", 32'(Busy), 32'd0);
        check("rst_sh_no_done", 32'(Done), 32'd0);
        check("rst_sh_ram", ram[1], 32'h11AB3344);
        check("rst_sh_readdata", ReadData, 32'h0);
        run_op("sw_after_rst", 1'b1, 3'd2, 32'h4, 32'hCAFEF00D);
        check("sw_after_rst_ram", ram[1], 32'hCAFEF00D);

        // MemReq held high across a LW: second request only in the IDLE cycle after Done
        poke(3, 32'h12345678);
        poke(5, 32'h9ABCDEF0);
        @(negedge clk);
        MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; ALUresult = 32'hC;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            busy_seq[k] = Busy;
            done_seq[k] = Done;
            if (k == 3) begin
                check("b2b_first_rd", ReadData, 32'h12345678);
                ALUresult = 32'h14;
            end
            if (k == 5) MemReq = 1'b0;
        end
        check("b2b_busy1", 32'(busy_seq[1]), 32'd1);
        check("b2b_busy2", 32'(busy_seq[2]), 32'd1);
        check("b2b_busy3", 32'(busy_seq[3]), 32'd0);
        check("b2b_busy4", 32'(busy_seq[4]), 32'd1);
        check("b2b_done2", 32'(done_seq[2]), 32'd1);
        check("b2b_done5", 32'(done_seq[5]), 32'd1);
        check("b2b_second_rd", ReadData, 32'h9ABCDEF0);
        exp_rd = 32'h9ABCDEF0;

        // Randomized traffic over a 16-word window, with garbage above the RAM address range
        for (int i = 0; i < 16; i++) poke(i, $urandom());
        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'd0;
                    1:       f3 = 3'd1;
                    2:       f3 = 3'd2;
                    3:       f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            addr = (32'($urandom_range(0, 1023)) << 22) | 32'($urandom_range(0, 63));
            run_op($sformatf("rnd%0d", n), wr, f3, addr, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
